// File: rtl/lfsr_engine_pkg.sv
// Shared types and constants for the LFSR engine.
// Imported by the step logic, the engine and the bench.
package lfsr_pkg;

  typedef enum logic {
    LFSR_FIBONACCI = 1'b0,
    LFSR_GALOIS    = 1'b1
  } lfsr_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } lfsr_state_e;

  localparam logic [3:0] LFSR_POLY_4 = 4'b1001;

endpackage

// File: rtl/lfsr_engine_if.sv
// Control and status bundle between an LFSR engine and its user.
// The master drives the controls; the engine is the slave.
interface lfsr_engine_if #(
  parameter int N = 4
) ();

  logic         load_seed;
  logic [N-1:0] seed_data;
  logic         mode;
  logic         stop_on_done;
  logic         enable;
  logic [N-1:0] lfsr_data;
  logic         lfsr_valid;
  logic         lfsr_done;
  logic [N-1:0] period;
  logic         lockup;

  modport master (
    output load_seed, seed_data, mode,
    output stop_on_done, enable,
    input  lfsr_data, lfsr_valid,
    input  lfsr_done, period, lockup
  );

  modport slave (
    input  load_seed, seed_data, mode,
    input  stop_on_done, enable,
    output lfsr_data, lfsr_valid,
    output lfsr_done, period, lockup
  );

endinterface

// File: rtl/lfsr_engine_step.sv
// Combinational next-state for Fibonacci and Galois LFSRs.
// POLY bit i is the x^i coefficient; x^N is implicit.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int           N    = 4,
  parameter logic [N-1:0] POLY = LFSR_POLY_4
) (
  input  logic [N-1:0] s,
  input  lfsr_mode_e   mode,
  output logic [N-1:0] next
);

  logic         fb;
  logic [N-1:0] fib;
  logic [N-1:0] gal;

  // Fibonacci tap for x^i reads the bit i places from the MSB.
  always_comb begin
    fb = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (POLY[i]) fb = fb ^ s[N-1-i];
    end
  end

  assign fib = {s[N-2:0], fb};
  assign gal = {s[N-2:0], 1'b0}
             ^ ({N{s[N-1]}} & POLY);

  always_comb begin
    next = fib;
    unique case (1'b1)
      (mode == LFSR_GALOIS):    next = gal;
      (mode == LFSR_FIBONACCI): next = fib;
    endcase
  end

endmodule

// File: rtl/lfsr_engine.sv
// Seeded LFSR engine: run/stop control, period measurement
// and zero-seed lockup protection.
module lfsr_engine
  import lfsr_pkg::*;
#(
  parameter int           N    = 4,
  parameter logic [N-1:0] POLY = LFSR_POLY_4
) (
  input logic          clk,
  input logic          reset,
  lfsr_engine_if.slave bus
);

  if (N < 3 || N > 32) begin : g_bad_n
    $error("lfsr_engine: N must be 3..32");
  end
  if (POLY[0] == 1'b0) begin : g_bad_poly
    $error("lfsr_engine: POLY[0] must be 1");
  end

  lfsr_state_e  state_q, state_d;
  lfsr_mode_e   mode_q;
  logic         stop_q;
  logic [N-1:0] seed_q;
  logic [N-1:0] data_q;
  logic [N-1:0] cnt_q;
  logic [N-1:0] period_q;
  logic         valid_q;
  logic         done_q;
  logic         lockup_q;

  logic [N-1:0] nxt;
  logic [N-1:0] seed_eff;
  logic         seed_zero;
  logic         do_step;
  logic         hit;

  lfsr_step #(
    .N    (N),
    .POLY (POLY)
  ) u_step (
    .s    (data_q),
    .mode (mode_q),
    .next (nxt)
  );

  // A zero seed would lock the register at zero forever.
  assign seed_zero = (bus.seed_data == '0);
  assign seed_eff  = seed_zero
                   ? {{(N-1){1'b0}}, 1'b1}
                   : bus.seed_data;
  assign hit       = (nxt == seed_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    do_step = 1'b0;
    if (bus.load_seed) begin
      state_d = RUN;
    end else begin
      unique case (state_q)
        RUN: begin
          if (bus.enable) begin
            do_step = 1'b1;
            if (hit && stop_q) state_d = DONE;
          end
        end
        IDLE, DONE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q   <= LFSR_FIBONACCI;
      stop_q   <= 1'b0;
      seed_q   <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      lockup_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.load_seed) begin
        mode_q   <= lfsr_mode_e'(bus.mode);
        stop_q   <= bus.stop_on_done;
        seed_q   <= seed_eff;
        data_q   <= seed_eff;
        cnt_q    <= '0;
        valid_q  <= 1'b1;
        lockup_q <= seed_zero;
      end else if (do_step) begin
        data_q <= nxt;
        if (hit) begin
          done_q   <= 1'b1;
          period_q <= cnt_q + 1'b1;
          cnt_q    <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign bus.lfsr_data  = data_q;
  assign bus.lfsr_valid = valid_q;
  assign bus.lfsr_done  = done_q;
  assign bus.period     = period_q;
  assign bus.lockup     = lockup_q;

endmodule

// File: tb/tb_lfsr_engine.sv
// Directed bench for lfsr_engine, N=4, POLY=1001.
// Expected sequences are hand-computed tables.
module tb_lfsr_engine;
  import lfsr_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  lfsr_engine_if #(.N(4)) bus ();

  lfsr_engine #(
    .N    (4),
    .POLY (4'b1001)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // State after k steps from seed 0001.
  logic [3:0] fib_t [15] = '{
    4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110,
    4'b1101, 4'b1010, 4'b0101, 4'b1011, 4'b0110,
    4'b1100, 4'b1001, 4'b0010, 4'b0100, 4'b1000
  };
  logic [3:0] gal_t [15] = '{
    4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1001,
    4'b1011, 4'b1111, 4'b0111, 4'b1110, 4'b0101,
    4'b1010, 4'b1101, 4'b0011, 4'b0110, 4'b1100
  };

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(
    input logic [3:0] seed,
    input logic       md,
    input logic       stop,
    input logic       en
  );
    bus.load_seed    = 1'b1;
    bus.seed_data    = seed;
    bus.mode         = md;
    bus.stop_on_done = stop;
    bus.enable       = en;
    tick();
    bus.load_seed = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".data"},   bus.lfsr_data,  0);
    check({tag, ".valid"},  bus.lfsr_valid, 0);
    check({tag, ".done"},   bus.lfsr_done,  0);
    check({tag, ".period"}, bus.period,     0);
    check({tag, ".lockup"}, bus.lockup,     0);
  endtask

  initial begin
    int idx;
    bus.load_seed    = 1'b0;
    bus.seed_data    = '0;
    bus.mode         = 1'b0;
    bus.stop_on_done = 1'b0;
    bus.enable       = 1'b1;

    tick();
    tick();
    check_zero("rst");
    reset = 1'b0;
    tick();
    check("idle.data", bus.lfsr_data, 0);
    check("idle.valid", bus.lfsr_valid, 0);

    // Fibonacci, free-running through the seed twice.
    load(4'b0001, 1'b0, 1'b0, 1'b1);
    check("fib.seed", bus.lfsr_data, 4'b0001);
    check("fib.valid", bus.lfsr_valid, 1);
    check("fib.lock", bus.lockup, 0);
    for (int k = 1; k <= 30; k++) begin
      tick();
      check($sformatf("fib.d%0d", k),
            bus.lfsr_data, fib_t[k % 15]);
      check($sformatf("fib.done%0d", k),
            bus.lfsr_done, (k % 15) == 0);
      if (k == 15) check("fib.per", bus.period, 15);
    end

    // Galois with stop: halts on the seed.
    load(4'b0001, 1'b1, 1'b1, 1'b1);
    check("gal.seed", bus.lfsr_data, 4'b0001);
    check("gal.perkeep", bus.period, 15);
    for (int k = 1; k <= 15; k++) begin
      tick();
      check($sformatf("gal.d%0d", k),
            bus.lfsr_data, gal_t[k % 15]);
      check($sformatf("gal.done%0d", k),
            bus.lfsr_done, k == 15);
    end
    check("gal.per", bus.period, 15);
    for (int k = 0; k < 10; k++) begin
      tick();
      check("hold.data", bus.lfsr_data, 4'b0001);
      check("hold.done", bus.lfsr_done, 0);
      check("hold.valid", bus.lfsr_valid, 1);
    end
    load(4'b0001, 1'b0, 1'b0, 1'b1);
    check("rest.seed", bus.lfsr_data, 4'b0001);
    tick();
    check("rest.d1", bus.lfsr_data, 4'b0011);

    // Zero seed replaced by 0001.
    load(4'b0000, 1'b0, 1'b0, 1'b1);
    check("zero.data", bus.lfsr_data, 4'b0001);
    check("zero.lock", bus.lockup, 1);
    tick();
    tick();
    check("zero.d2", bus.lfsr_data, 4'b0111);
    check("zero.lockhold", bus.lockup, 1);
    load(4'b0101, 1'b0, 1'b0, 1'b1);
    check("nz.data", bus.lfsr_data, 4'b0101);
    check("nz.lock", bus.lockup, 0);

    // Clear period, then step only on every other edge.
    reset = 1'b1;
    tick();
    check("rst2.per", bus.period, 0);
    reset = 1'b0;
    load(4'b0001, 1'b0, 1'b0, 1'b1);
    idx = 0;
    for (int c = 0; c < 30; c++) begin
      bus.enable = (c % 2) == 0;
      tick();
      if (bus.enable) idx++;
      check($sformatf("tog.d%0d", c),
            bus.lfsr_data, fib_t[idx % 15]);
      check($sformatf("tog.done%0d", c),
            bus.lfsr_done, bus.enable && idx == 15);
    end
    check("tog.per", bus.period, 15);

    // load_seed wins over enable; no step on that edge.
    tick();
    load(4'b0101, 1'b0, 1'b0, 1'b1);
    check("pri.data", bus.lfsr_data, 4'b0101);
    tick();
    check("pri.d1", bus.lfsr_data, 4'b1011);

    // Async reset at step 7 aborts the run.
    load(4'b0001, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 7; k++) tick();
    check("ab.d7", bus.lfsr_data, fib_t[7]);
    #2;
    reset = 1'b1;
    #1;
    check_zero("async");
    tick();
    check_zero("inrst");
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      check("post.done", bus.lfsr_done, 0);
      check("post.valid", bus.lfsr_valid, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lfsr_engine.md
LFSR_ENGINE -- requirements
Module: lfsr_engine

Interface
REQ-001 SHALL have parameter N, default 4, meaning state width; legal range 3..32.
REQ-002 SHALL have parameter POLY, default 4'b1001, meaning characteristic polynomial: bit i is the x^i coefficient, x^N implicit; elaboration SHALL fail if POLY[0]==0.
REQ-003 Ports SHALL be:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- load_seed  in  1  load seed_data and start a run.
- seed_data  in  N  seed value.
- mode  in  1  0 = Fibonacci, 1 = Galois; sampled only with load_seed.
- stop_on_done  in  1  1 = halt when the sequence returns to seed; sampled only with load_seed.
- enable  in  1  advance one step per cycle while RUN.
- lfsr_data  out  N  current state.
- lfsr_valid  out  1  lfsr_data holds a seeded sequence value.
- lfsr_done  out  1  one-cycle pulse when the state returns to the seed.
- period  out  N  step count of the last completed cycle.
- lockup  out  1  zero seed was replaced.

Function
REQ-004 FSM states SHALL be IDLE, RUN and DONE.
- IDLE to RUN on load_seed.
- RUN to DONE on a done step when stop_on_done is latched 1.
- Any state to RUN on load_seed.
REQ-005 On a load_seed edge, the block SHALL:
- latch mode, stop_on_done and the effective seed (seed_data, or {N-1 zeros,1} if seed_data==0);
- set lfsr_data = effective seed, lfsr_valid=1, step counter=0;
- set lockup=1 if seed_data==0, else 0.
REQ-006 load_seed SHALL take priority over enable in the same cycle; no step occurs on that edge.
REQ-007 In RUN with enable=1, each edge SHALL set lfsr_data to next(s); with enable=0, state and counter SHALL hold.
REQ-008 Fibonacci next(s) SHALL be {s[N-2:0], f}, where f = XOR of s[N-1-i] over every i with POLY[i]==1.
REQ-009 Galois next(s) SHALL be {s[N-2:0],1'b0} XOR ({N{s[N-1]}} AND POLY).
REQ-010 The step counter SHALL be N bits and increment on each step. When next(s) equals the latched seed:
- lfsr_done SHALL pulse high for exactly that edge's cycle;
- period SHALL register counter+1;
- the counter SHALL clear to 0.
REQ-011 In DONE, lfsr_data SHALL hold the seed, enable SHALL be ignored, and lfsr_valid SHALL remain 1.
REQ-012 With stop_on_done=0, the sequence SHALL wrap through the seed, pulsing lfsr_done on every return.
REQ-013 period SHALL hold its value until the next done step or reset; load_seed SHALL NOT clear it.
REQ-014 lockup SHALL stay set until the next load_seed or reset.
REQ-015 Latency SHALL be one edge from load_seed to a visible seed, and one edge per step.

Reset
REQ-016 While reset is high, and immediately on assertion, outputs SHALL be: lfsr_data=0, lfsr_valid=0, lfsr_done=0, period=0, lockup=0; FSM=IDLE; counter=0; latched mode=Fibonacci; latched stop_on_done=0.
REQ-017 Reset asserted mid-run SHALL abort the run; no lfsr_done SHALL be emitted after deassertion until a new load_seed.
REQ-018 In IDLE, enable SHALL have no effect.

Structure
REQ-019 Shared package lfsr_pkg SHALL hold:
- lfsr_mode_e (LFSR_FIBONACCI=0, LFSR_GALOIS=1);
- lfsr_state_e (IDLE, RUN, DONE);
- default POLY constant LFSR_POLY_4 = 4'b1001.
REQ-020 Next-state logic SHALL be a combinational sub-module lfsr_step (parameters N and POLY; inputs s and mode; output next).

Verification
REQ-021 N=4, Fibonacci, seed 4'b0001, enable=1 -> lfsr_data 0001, 0011, 0111, 1111, 1110 ...; lfsr_done on the 15th step; period=15.
REQ-022 N=4, Galois, seed 4'b0001 -> 0010, 0100, 1000, 1001, 1011 ...; lfsr_done after 15 steps; period=15.
REQ-023 Seed 4'b0000 -> lfsr_data=0001 and lockup=1 one edge after load_seed; lockup clears on the next non-zero load.
REQ-024 stop_on_done=1 -> after done, FSM=DONE and lfsr_data=seed held for 10 enabled cycles; a new load_seed restarts the run.
REQ-025 enable toggled every other cycle -> state advances only on enabled edges; period is still 15; load_seed and enable high together -> seed loaded with no step.
REQ-026 reset pulsed at step 7 -> all outputs 0 during reset; no lfsr_done afterwards until a new load_seed; with stop_on_done=0, lfsr_done pulses every 15 steps.
